// File: rtl/kuuga_sa_cache.sv
// kuuga_sa_cache: N-way set-associative, write-through, no-write-allocate
// cache with one word per line, per-set round-robin replacement, a
// single-cycle flush and free-running request/hit/miss counters.
module kuuga_sa_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 64,
    parameter int NUM_WAYS   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    core_req_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    input  logic                    core_we_i,
    input  logic [DATA_WIDTH/8-1:0] core_be_i,
    input  logic [DATA_WIDTH-1:0]   core_wdata_i,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    flush_i,
    output logic [31:0]             req_count_o,
    output logic [31:0]             hit_count_o,
    output logic [31:0]             miss_count_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_MEM_REQ  = 3'd2;
    localparam logic [2:0] S_MEM_WAIT = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    // Byte-enable merge of new write data into an existing line word.
    function automatic logic [DATA_WIDTH-1:0] merge_be(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BE_W-1:0]       be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [BE_W-1:0]       be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [WAY_W-1:0]      rr_q    [NUM_SETS];
    logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];

    logic [31:0]           req_cnt_q, hit_cnt_q, miss_cnt_q;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [DATA_WIDTH-1:0] hit_data;
    logic [WAY_W-1:0]      victim;
    logic                  victim_inv;
    logic                  fill;
    logic                  lookup_rd_hit;
    logic [ADDR_WIDTH-1:0] aligned_addr;

    assign idx          = addr_q[OFF_W +: IDX_W];
    assign tag          = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign aligned_addr = addr_q & ~ADDR_WIDTH'(BE_W - 1);
    assign fill         = (state_q == S_MEM_WAIT) && !we_q && mem_rvalid_i;
    assign lookup_rd_hit = (state_q == S_LOOKUP) && !we_q && hit;

    // Tag compare across all ways of the indexed set; lowest matching way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        hit_data = data_q[idx][hit_way];
    end

    // Victim selection: lowest invalid way first, else the set's RR way.
    always_comb begin
        victim     = rr_q[idx];
        victim_inv = 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                victim     = WAY_W'(w);
                victim_inv = 1'b1;
            end
        end
    end

    // Next-state logic for the request FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (core_req_i && !flush_i) state_d = S_LOOKUP;
            S_LOOKUP:   state_d = (!we_q && hit) ? S_IDLE : S_MEM_REQ;
            S_MEM_REQ:  if (mem_gnt_i) state_d = S_MEM_WAIT;
            S_MEM_WAIT: if (mem_rvalid_i) state_d = S_RESP;
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Control state: FSM, valid bits, RR pointers and statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_cnt_q  <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && flush_i) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid_q[s] <= '0;
                    rr_q[s]    <= '0;
                end
            end
            if (core_gnt_o) req_cnt_q <= req_cnt_q + 32'd1;
            if (state_q == S_LOOKUP) begin
                if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
                else     miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            if (fill) begin
                valid_q[idx][victim] <= 1'b1;
                // Filling an empty way leaves the rotation untouched.
                if (!victim_inv) begin
                    rr_q[idx] <= (rr_q[idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
                end
            end
        end
    end

    // Datapath: request capture, write-hit merge, line fill and read-data hold.
    always_ff @(posedge clk) begin
        if (core_gnt_o) begin
            addr_q  <= core_addr_i;
            we_q    <= core_we_i;
            be_q    <= core_be_i;
            wdata_q <= core_wdata_i;
        end
        if (state_q == S_LOOKUP && we_q && hit) begin
            data_q[idx][hit_way] <= merge_be(hit_data, wdata_q, be_q);
        end
        if (fill) begin
            tag_q[idx][victim]  <= tag;
            data_q[idx][victim] <= mem_rdata_i;
        end
        if (state_q == S_MEM_WAIT && mem_rvalid_i) rdata_q <= mem_rdata_i;
    end

    assign core_gnt_o    = (state_q == S_IDLE) && core_req_i && !flush_i;
    assign core_rvalid_o = lookup_rd_hit || (state_q == S_RESP);
    assign core_rdata_o  = lookup_rd_hit                   ? hit_data :
                           (state_q == S_RESP && !we_q)    ? rdata_q  : '0;

    // Memory outputs are decoded from state so reset clears them at once.
    assign mem_req_o   = (state_q == S_MEM_REQ);
    assign mem_addr_o  = mem_req_o ? (we_q ? addr_q : aligned_addr) : '0;
    assign mem_we_o    = mem_req_o && we_q;
    assign mem_be_o    = mem_req_o ? (we_q ? be_q : '1) : '0;
    assign mem_wdata_o = (mem_req_o && we_q) ? wdata_q : '0;

    assign req_count_o  = req_cnt_q;
    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_kuuga_sa_cache.sv
// Directed bench for kuuga_sa_cache: a table of core transactions with
// hand-computed responses, plus hand-written flush and reset sequences.
module tb_kuuga_sa_cache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_gnt_o;
    logic        core_rvalid_o;
    logic [31:0] core_addr_i = '0;
    logic        core_we_i = 1'b0;
    logic [3:0]  core_be_i = '0;
    logic [31:0] core_wdata_i = '0;
    logic [31:0] core_rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] req_count_o, hit_count_o, miss_count_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    kuuga_sa_cache #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SETS(64), .NUM_WAYS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_addr_i(core_addr_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
        .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .flush_i(flush_i),
        .req_count_o(req_count_o), .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          gw;        // cycles mem_gnt_i is withheld
        int          rw;        // cycles mem_rvalid_i is withheld after grant
        logic [31:0] mrd;       // word the memory returns
        logic        exp_mem;   // a memory access is required
        logic [31:0] exp_maddr;
        logic [3:0]  exp_mbe;
        int          exp_lat;   // cycles from grant to core_rvalid_o
        logic [31:0] exp_rd;
        logic [31:0] exp_req, exp_hit, exp_miss;
    } vec_t;

    vec_t vec [18];

    function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] wd, input int gw, input int rw,
                                input logic [31:0] mrd, input logic em, input logic [31:0] ema,
                                input logic [3:0] embe, input int lat, input logic [31:0] erd,
                                input int er, input int eh, input int emi);
        vec_t v;
        v.we = we; v.addr = a; v.be = be; v.wdata = wd; v.gw = gw; v.rw = rw;
        v.mrd = mrd; v.exp_mem = em; v.exp_maddr = ema; v.exp_mbe = embe;
        v.exp_lat = lat; v.exp_rd = erd;
        v.exp_req = 32'(er); v.exp_hit = 32'(eh); v.exp_miss = 32'(emi);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Issue one core transaction, play the memory side, and check the result.
    task automatic run_vec(input int i);
        vec_t        v;
        int          gw, rw, rv_cyc, nrv;
        bit          seen, granted, rv_sent, unstable;
        logic [31:0] maddr, mwd, rd;
        logic [3:0]  mbe;
        logic        mwe;
        v = vec[i];
        gw = v.gw; rw = v.rw; rv_cyc = 0; nrv = 0;
        seen = 0; granted = 0; rv_sent = 0; unstable = 0;
        maddr = '0; mwd = '0; rd = '0; mbe = '0; mwe = 1'b0;
        @(negedge clk);
        core_req_i = 1'b1; core_we_i = v.we; core_addr_i = v.addr;
        core_be_i = v.be; core_wdata_i = v.wdata;
        #1 chk($sformatf("v%0d gnt", i), {31'd0, core_gnt_o}, 32'd1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            core_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
            if (core_rvalid_o) begin
                nrv++;
                if (nrv == 1) begin
                    rv_cyc = c;
                    rd = core_rdata_o;
                end
            end
            if (mem_req_o) begin
                if (!seen) begin
                    seen = 1; maddr = mem_addr_o; mbe = mem_be_o; mwe = mem_we_o; mwd = mem_wdata_o;
                end else if (mem_addr_o !== maddr || mem_be_o !== mbe || mem_we_o !== mwe
                             || mem_wdata_o !== mwd) begin
                    unstable = 1;
                end
                if (gw == 0) begin
                    mem_gnt_i = 1'b1;
                    granted = 1;
                end else gw--;
            end else if (granted && !rv_sent) begin
                if (rw == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i = v.mrd;
                    rv_sent = 1;
                end else rw--;
            end
            if (rv_cyc > 0 && c >= rv_cyc + 2) break;
        end
        chk($sformatf("v%0d latency", i), 32'(rv_cyc), 32'(v.exp_lat));
        chk($sformatf("v%0d rdata", i), rd, v.exp_rd);
        chk($sformatf("v%0d rvalid pulses", i), 32'(nrv), 32'd1);
        chk($sformatf("v%0d mem access", i), {31'd0, seen}, {31'd0, v.exp_mem});
        if (v.exp_mem) begin
            chk($sformatf("v%0d mem addr", i), maddr, v.exp_maddr);
            chk($sformatf("v%0d mem be", i), {28'd0, mbe}, {28'd0, v.exp_mbe});
            chk($sformatf("v%0d mem we", i), {31'd0, mwe}, {31'd0, v.we});
            chk($sformatf("v%0d mem hold", i), {31'd0, unstable}, 32'd0);
            if (v.we) chk($sformatf("v%0d mem wdata", i), mwd, v.wdata);
        end
        chk($sformatf("v%0d req cnt", i), req_count_o, v.exp_req);
        chk($sformatf("v%0d hit cnt", i), hit_count_o, v.exp_hit);
        chk($sformatf("v%0d miss cnt", i), miss_count_o, v.exp_miss);
    endtask

    // Start a read and stop once it has reached MEM_REQ (cycle T+2).
    task automatic start_miss(input logic [31:0] a);
        @(negedge clk);
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = a; core_be_i = 4'hF;
        @(negedge clk);
        core_req_i = 1'b0;
        @(negedge clk);
        chk("pre-reset mem_req", {31'd0, mem_req_o}, 32'd1);
    endtask

    int nrv_after, nmr_after;

    initial begin
        // Set 0 holds 0x000/0x100/0x200/0x300 (tags 0..3); 0x104-0x107 is set 1.
        vec[0]  = mk(0, 32'h000, 4'hF, 0, 0, 0, 32'h0000_0A00, 1, 32'h000, 4'hF, 4, 32'h0000_0A00, 1, 0, 1);
        vec[1]  = mk(0, 32'h100, 4'hF, 0, 0, 0, 32'hDEAD_BEEF, 1, 32'h100, 4'hF, 4, 32'hDEAD_BEEF, 2, 0, 2);
        vec[2]  = mk(0, 32'h100, 4'hF, 0, 0, 0, 32'h0,         0, 32'h0,   4'h0, 1, 32'hDEAD_BEEF, 3, 1, 2);
        vec[3]  = mk(0, 32'h200, 4'hF, 0, 1, 2, 32'h0000_0C00, 1, 32'h200, 4'hF, 7, 32'h0000_0C00, 4, 1, 3);
        vec[4]  = mk(0, 32'h100, 4'hF, 0, 0, 0, 32'h0,         0, 32'h0,   4'h0, 1, 32'hDEAD_BEEF, 5, 2, 3);
        vec[5]  = mk(0, 32'h000, 4'hF, 0, 2, 0, 32'h0000_0A00, 1, 32'h000, 4'hF, 6, 32'h0000_0A00, 6, 2, 4);
        vec[6]  = mk(0, 32'h200, 4'hF, 0, 0, 0, 32'h0,         0, 32'h0,   4'h0, 1, 32'h0000_0C00, 7, 3, 4);
        vec[7]  = mk(0, 32'h100, 4'hF, 0, 0, 0, 32'hDEAD_BEEF, 1, 32'h100, 4'hF, 4, 32'hDEAD_BEEF, 8, 3, 5);
        vec[8]  = mk(1, 32'h100, 4'h3, 32'h1234_5678, 0, 1, 32'h0, 1, 32'h100, 4'h3, 5, 32'h0, 9, 4, 5);
        vec[9]  = mk(0, 32'h100, 4'hF, 0, 0, 0, 32'h0,         0, 32'h0,   4'h0, 1, 32'hDEAD_5678, 10, 5, 5);
        vec[10] = mk(1, 32'h300, 4'hF, 32'hCAFE_F00D, 0, 0, 32'h0, 1, 32'h300, 4'hF, 4, 32'h0, 11, 5, 6);
        vec[11] = mk(0, 32'h300, 4'hF, 0, 0, 0, 32'h3333_3333, 1, 32'h300, 4'hF, 4, 32'h3333_3333, 12, 5, 7);
        vec[12] = mk(0, 32'h107, 4'hF, 0, 0, 0, 32'h0107_0107, 1, 32'h104, 4'hF, 4, 32'h0107_0107, 13, 5, 8);
        vec[13] = mk(0, 32'h104, 4'hF, 0, 0, 0, 32'h0,         0, 32'h0,   4'h0, 1, 32'h0107_0107, 14, 6, 8);
        // After flush: previously cached lines must miss.
        vec[14] = mk(0, 32'h100, 4'hF, 0, 0, 0, 32'hDEAD_BEEF, 1, 32'h100, 4'hF, 4, 32'hDEAD_BEEF, 15, 6, 9);
        vec[15] = mk(0, 32'h300, 4'hF, 0, 0, 0, 32'h3333_3333, 1, 32'h300, 4'hF, 4, 32'h3333_3333, 16, 6, 10);
        vec[16] = mk(0, 32'h104, 4'hF, 0, 0, 0, 32'h0107_0107, 1, 32'h104, 4'hF, 4, 32'h0107_0107, 17, 6, 11);
        // After reset: 0x100 was cached but must miss, counters restart.
        vec[17] = mk(0, 32'h100, 4'hF, 0, 0, 0, 32'hDEAD_BEEF, 1, 32'h100, 4'hF, 4, 32'hDEAD_BEEF, 1, 0, 1);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset gnt", {31'd0, core_gnt_o}, 32'd0);
        chk("reset rvalid", {31'd0, core_rvalid_o}, 32'd0);
        chk("reset mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("reset mem_addr", mem_addr_o, 32'd0);
        chk("reset req cnt", req_count_o, 32'd0);
        chk("reset miss cnt", miss_count_o, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i <= 13; i++) run_vec(i);

        // Flush and request in the same IDLE cycle: flush wins.
        @(negedge clk);
        flush_i = 1'b1; core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h100;
        #1 chk("flush gnt", {31'd0, core_gnt_o}, 32'd0);
        @(negedge clk);
        flush_i = 1'b0; core_req_i = 1'b0;
        #1 chk("flush no lookup", {31'd0, core_rvalid_o}, 32'd0);
        chk("flush req cnt", req_count_o, 32'd14);

        for (int i = 14; i <= 16; i++) run_vec(i);

        // Reset asserted mid-cycle while in MEM_WAIT.
        start_miss(32'h200);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("rst wait mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst wait req cnt", req_count_o, 32'd0);
        chk("rst wait hit cnt", hit_count_o, 32'd0);
        chk("rst wait miss cnt", miss_count_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-cycle while mem_req_o is high: it drops at once.
        start_miss(32'h000);
        #2 rst_n = 1'b0;
        #1 chk("rst req mem_req", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nrv_after = 0; nmr_after = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (core_rvalid_o) nrv_after++;
            if (mem_req_o) nmr_after++;
        end
        chk("aborted rvalid", 32'(nrv_after), 32'd0);
        chk("aborted mem_req", 32'(nmr_after), 32'd0);

        run_vec(17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/kuuga_sa_cache.md
# kuuga_sa_cache

Parametrised N-way set-associative, write-through, no-write-allocate cache sitting between a core data or instruction port (req/gnt/rvalid protocol) and a word-wide memory port of the same protocol. It generalises the team's direct-mapped cache in three ways: configurable sets, ways and widths; per-set round-robin replacement; and a one-cycle full flush. It also exports request, hit and miss counters so the simulation bench reads cache statistics directly rather than counting them itself.

## Interface
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; BE width is DATA_WIDTH/8.
- NUM_SETS, 64, power of 2, ≥2.
- NUM_WAYS, 2, power of 2, 1..8; 1 gives direct-mapped behaviour.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_req_i / core_gnt_o / core_rvalid_o  in/out/out  1  core handshake.
- core_addr_i  in  ADDR_WIDTH; core_we_i  in  1; core_be_i  in  DATA_WIDTH/8; core_wdata_i  in  DATA_WIDTH.
- core_rdata_o  out  DATA_WIDTH  read data, valid with core_rvalid_o.
- mem_req_o / mem_gnt_i / mem_rvalid_i  out/in/in  1  memory handshake.
- mem_addr_o  out  ADDR_WIDTH; mem_we_o  out  1; mem_be_o  out  DATA_WIDTH/8; mem_wdata_o  out  DATA_WIDTH; mem_rdata_i  in  DATA_WIDTH.
- flush_i  in  1  invalidate all lines.
- req_count_o, hit_count_o, miss_count_o  out  32 each  statistics, wrap modulo 2^32.

## Operation
- Address split: offset = log2(DATA_WIDTH/8) LSBs; index = next log2(NUM_SETS) bits; tag = remainder. One word per line.
- Storage per way per set: valid, tag, data word. Per set: round-robin pointer, log2(NUM_WAYS) bits.
- FSM states: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP.
- IDLE:
  - flush_i=1 clears all valid bits and all RR pointers; core_gnt_o=0 that cycle (flush wins over a simultaneous req).
  - Otherwise core_gnt_o = core_req_i (combinational). On grant, register addr/we/be/wdata, increment req_count, go to LOOKUP.
- LOOKUP: compare the tag against all ways of the indexed set.
  - Read hit: core_rvalid_o=1, core_rdata_o = hit way data; hit_count++; go to IDLE.
  - Read miss: miss_count++; go to MEM_REQ.
  - Write hit: merge wdata into the line under be; hit_count++; go to MEM_REQ.
  - Write miss: miss_count++; no allocation; go to MEM_REQ.
- MEM_REQ: mem_req_o=1 with registered address.
  - Read: mem_we_o=0, mem_be_o all ones, mem_addr_o word-aligned.
  - Write: registered we/be/wdata passed through unchanged.
  - Hold all mem outputs stable until mem_gnt_i, then go to MEM_WAIT.
- MEM_WAIT: wait for mem_rvalid_i.
  - Read: capture mem_rdata_i. Victim = lowest-index invalid way; if none, the RR way, and the RR pointer then increments modulo NUM_WAYS. Invalid-way fills do not move the pointer. Write tag, data and valid; go to RESP.
  - Write: go to RESP.
- RESP: core_rvalid_o=1 for one cycle. core_rdata_o = filled word on reads, 0 on writes. Go to IDLE.
- flush_i outside IDLE is ignored; it must be held until IDLE to take effect.

## Timing
- Reset values: all outputs 0; FSM in IDLE; all valid bits and RR pointers 0; counters 0. Reset mid-transaction aborts it immediately (mem_req_o drops asynchronously); the in-flight core request is never answered.
- One outstanding core request; core_gnt_o is 0 outside IDLE.
- Read hit: grant in cycle T, core_rvalid_o in T+1.
- Miss or write: mem_req_o rises at T+2. With mem_gnt_i at T+2 and mem_rvalid_i at T+3, core_rvalid_o is at T+4. Each extra gnt or rvalid wait cycle adds one cycle.
- Counters update on the clock edge ending LOOKUP, so they are visible from T+2.
- core_rvalid_o is a single-cycle pulse, one per granted request.

## Test plan
- Cold read 0x100, memory returns 0xDEADBEEF: mem_addr_o=0x100, core_rdata_o=0xDEADBEEF at T+4. Repeat read: rvalid at T+1, mem_req_o stays 0. Counts req/hit/miss = 2/1/1.
- Set conflict (64 sets, 2 ways): read 0x000, 0x100, 0x200, then 0x100 and 0x000. Required: 0x200 evicts 0x000 (way 0); 0x100 hits; 0x000 misses.
- Write hit: 0x100 cached as 0xDEADBEEF; write be=0011, wdata=0x12345678. Required: mem write with be=0011, addr 0x100. Subsequent read of 0x100 hits and returns 0xDEAD5678.
- Write miss to 0x300, then read 0x300: the read misses and issues a mem read (no allocation on write).
- Flush: with lines valid, flush_i=1 and core_req_i=1 in the same IDLE cycle. Required: core_gnt_o=0 that cycle; every following read misses.
- rst_n low while in MEM_WAIT: mem_req_o=0 and counters 0 immediately. After release, a read of a previously cached address misses.
